// File: rtl/mr_pctr_apb_if.sv
// rtl/mr_pctr_apb_if.sv - APB3 register-bus bundle for the counter readout stage
interface mr_pctr_apb_if #(
    parameter int ADDR_W = 12
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/mr_pctr_apb.sv
// rtl/mr_pctr_apb.sv - atomic snapshot of the counter bank served over APB3
module mr_pctr_apb #(
    parameter int NUM_CTRS = 64,
    parameter int ADDR_W   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CTRS*32-1:0] ctrs_in,
    input  logic [31:0]            cctr_in,
    mr_pctr_apb_if.slave           apb,
    output logic                   ctr_clear
);
    localparam int          CTR_IW     = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;
    localparam logic [31:0] CTR_BASE_W = 32'd64;   // word index of SNAPCTR[0] (byte 0x100)

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state;

    // architectural registers
    logic [31:0] period_q;
    logic [31:0] timer_q;
    logic [31:0] snap_cyc;
    logic [31:0] snap_ctr [NUM_CTRS];
    logic        valid_q;
    logic        sat_q;
    logic [15:0] seq_q;

    // write captured in WAIT, committed at the edge that ends RESP
    logic        wr_ctrl_q;
    logic        wr_period_q;
    logic [31:0] wdata_q;

    // address decode
    logic [31:0]       word;
    logic              in_ctr;
    logic [CTR_IW-1:0] ctr_idx;
    logic              dec_err;
    logic              dec_wr_ctrl;
    logic              dec_wr_period;
    logic [31:0]       dec_rdata;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^apb.paddr[1:0];

    // Decode the current address into read data / error / write target.
    always_comb begin
        word          = 32'(apb.paddr[ADDR_W-1:2]);
        in_ctr        = (word >= CTR_BASE_W) && (word < CTR_BASE_W + 32'(NUM_CTRS));
        ctr_idx       = CTR_IW'(word - CTR_BASE_W);
        dec_err       = 1'b0;
        dec_wr_ctrl   = 1'b0;
        dec_wr_period = 1'b0;
        dec_rdata     = 32'd0;
        if (apb.pwrite) begin
            if (word == 32'd0)      dec_wr_ctrl   = 1'b1;
            else if (word == 32'd2) dec_wr_period = 1'b1;
            else                    dec_err       = 1'b1;
        end else begin
            case (word)
                32'd0:   dec_rdata = 32'd0;
                32'd1:   dec_rdata = {seq_q, 14'd0, sat_q, valid_q};
                32'd2:   dec_rdata = period_q;
                32'd3:   dec_rdata = snap_cyc;
                default: begin
                    if (in_ctr) dec_rdata = snap_ctr[ctr_idx];
                    else        dec_err   = 1'b1;
                end
            endcase
        end
    end

    // APB transfer sequencing with registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= 32'd0;
            wr_ctrl_q   <= 1'b0;
            wr_period_q <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    apb.pready  <= 1'b0;
                    apb.pslverr <= 1'b0;
                    apb.prdata  <= 32'd0;
                    wr_ctrl_q   <= 1'b0;
                    wr_period_q <= 1'b0;
                    if (apb.psel && !apb.penable) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!apb.psel) begin
                        state <= S_IDLE;
                    end else begin
                        state       <= S_RESP;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= dec_err;
                        apb.prdata  <= dec_rdata;
                        wr_ctrl_q   <= dec_wr_ctrl;
                        wr_period_q <= dec_wr_period;
                        wdata_q     <= apb.pwdata;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    apb.pready  <= 1'b0;
                    apb.pslverr <= 1'b0;
                    apb.prdata  <= 32'd0;
                    wr_ctrl_q   <= 1'b0;
                    wr_period_q <= 1'b0;
                end
            endcase
        end
    end

    logic commit;
    logic sw_snap;
    logic sw_clear;
    logic period_wr;
    logic tmr_fire;
    logic do_snap;
    logic cap_sat;

    assign commit    = (state == S_RESP);
    assign sw_snap   = commit && wr_ctrl_q && wdata_q[0];
    assign sw_clear  = commit && wr_ctrl_q && wdata_q[1];
    assign period_wr = commit && wr_period_q;
    assign tmr_fire  = (period_q != 32'd0) && (timer_q == 32'd1);
    assign do_snap   = sw_snap || tmr_fire;   // coincident triggers merge into one snapshot

    // Saturation flag computed from the values about to be captured.
    always_comb begin
        cap_sat = 1'b0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (ctrs_in[32*i +: 32] == 32'hFFFF_FFFF) cap_sat = 1'b1;
        end
    end

    // Timer, clear pulse and shadow capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_clear <= 1'b0;
            period_q  <= 32'd0;
            timer_q   <= 32'd0;
            snap_cyc  <= 32'd0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            seq_q     <= 16'd0;
            for (int i = 0; i < NUM_CTRS; i++) snap_ctr[i] <= 32'd0;
        end else begin
            ctr_clear <= sw_clear;
            if (period_wr) begin
                period_q <= wdata_q;
                timer_q  <= wdata_q;
            end else if (period_q != 32'd0) begin
                if (timer_q <= 32'd1) timer_q <= period_q;
                else                  timer_q <= timer_q - 32'd1;
            end
            if (do_snap) begin
                for (int i = 0; i < NUM_CTRS; i++) snap_ctr[i] <= ctrs_in[32*i +: 32];
                snap_cyc <= cctr_in;
                sat_q    <= cap_sat;
                valid_q  <= 1'b1;
                seq_q    <= seq_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mr_pctr_apb.sv
// tb/tb_mr_pctr_apb.sv - randomized self-checking bench for mr_pctr_apb
module tb_mr_pctr_apb;
    localparam int NUM = 64;
    localparam int AW  = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic [NUM*32-1:0] ctrs_in;
    logic [31:0]      cctr_in = 32'd0;
    logic             ctr_clear;

    mr_pctr_apb_if #(.ADDR_W(AW)) apb ();

    mr_pctr_apb #(.NUM_CTRS(NUM), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrs_in  (ctrs_in),
        .cctr_in  (cctr_in),
        .apb      (apb),
        .ctr_clear(ctr_clear)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // stimulus modes: 0 ramp i*16, 1 random, 2 random with counter 3 pinned at all-ones
    int   ctr_mode = 0;
    logic cctr_run = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (ctr_mode == 0)                   ctrs_in[32*i +: 32] = 32'(i * 16);
            else if (ctr_mode == 2 && i == 3)    ctrs_in[32*i +: 32] = 32'hFFFF_FFFF;
            else if ($urandom_range(0, 15) == 0) ctrs_in[32*i +: 32] = 32'hFFFF_FFFF;
            else                                 ctrs_in[32*i +: 32] = $urandom;
        end
        if (cctr_run) cctr_in = cctr_in + 32'd1;
        else          cctr_in = 32'h1234;
    end

    // ---------------- reference model ----------------
    logic        pend_wr = 1'b0;
    logic [11:0] pend_addr = '0;
    logic [31:0] pend_data = '0;

    longint      cyc = 0;
    longint      m_t0 = 0;
    logic [31:0] m_period = '0;
    logic [31:0] m_snap [NUM];
    logic [31:0] m_snapcyc = '0;
    logic        m_valid = 1'b0;
    logic        m_sat = 1'b0;
    logic [15:0] m_seq = '0;
    logic        m_clr = 1'b0;

    longint edge_n;
    logic   m_fire, m_sw, m_swclr, m_snap_now, m_cap_sat;

    // snapshot every m_period edges counted from the PERIOD commit edge
    always_comb begin
        edge_n = cyc + 1;
        m_fire = 1'b0;
        if (m_period != 0 && edge_n > m_t0)
            m_fire = (((edge_n - m_t0) % longint'(m_period)) == 0);
        m_sw       = pend_wr && (pend_addr[11:2] == 10'd0) && pend_data[0];
        m_swclr    = pend_wr && (pend_addr[11:2] == 10'd0) && pend_data[1];
        m_snap_now = m_fire || m_sw;
        m_cap_sat  = 1'b0;
        for (int i = 0; i < NUM; i++)
            if (ctrs_in[32*i +: 32] == 32'hFFFF_FFFF) m_cap_sat = 1'b1;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_period  <= '0;
            m_t0      <= 0;
            m_snapcyc <= '0;
            m_valid   <= 1'b0;
            m_sat     <= 1'b0;
            m_seq     <= '0;
            m_clr     <= 1'b0;
            for (int i = 0; i < NUM; i++) m_snap[i] <= '0;
        end else begin
            if (m_snap_now) begin
                for (int i = 0; i < NUM; i++) m_snap[i] <= ctrs_in[32*i +: 32];
                m_snapcyc <= cctr_in;
                m_sat     <= m_cap_sat;
                m_valid   <= 1'b1;
                m_seq     <= m_seq + 16'd1;
            end
            m_clr <= m_swclr;
            if (pend_wr && pend_addr[11:2] == 10'd2) begin
                m_period <= pend_data;
                m_t0     <= edge_n;
            end
        end
        cyc <= cyc + 1;
    end

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        int w;
        w = int'(a[11:2]);
        d = '0;
        e = 1'b0;
        case (w)
            0: d = '0;
            1: d = {m_seq, 14'd0, m_sat, m_valid};
            2: d = m_period;
            3: d = m_snapcyc;
            default: begin
                if (w >= 64 && w < 64 + NUM) d = m_snap[w - 64];
                else                         e = 1'b1;
            end
        endcase
    endfunction

    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) check_eq("ctr_clear", 32'(ctr_clear), 32'(m_clr));
    end

    // one complete APB transfer: setup + two access cycles, checked against the model
    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
        logic [31:0] exp_d;
        logic        exp_e;
        int          guard;
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = wd;
        @(negedge clk);
        apb.penable = 1'b1;
        model_read(a, exp_d, exp_e);
        if (wr) begin
            exp_d = '0;
            exp_e = (a[11:2] != 10'd0) && (a[11:2] != 10'd2);
        end
        check_eq($sformatf("pready_wait_%03h", a), 32'(apb.pready), 32'd0);
        check_eq($sformatf("prdata_wait_%03h", a), apb.prdata, 32'd0);
        @(negedge clk);
        guard = 0;
        while (!apb.pready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check_eq($sformatf("resp_latency_%03h", a), 32'(guard), 32'd0);
        rd = apb.prdata;
        er = apb.pslverr;
        check_eq($sformatf("%s_data_%03h", wr ? "wr" : "rd", a), rd, exp_d);
        check_eq($sformatf("%s_err_%03h", wr ? "wr" : "rd", a), 32'(er), 32'(exp_e));
        if (wr) begin
            pend_wr = 1'b1; pend_addr = a; pend_data = wd;
        end
        @(negedge clk);
        pend_wr = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0;
        check_eq("pready_after", 32'(apb.pready), 32'd0);
    endtask

    logic [31:0] rd, s1, s2;
    logic        er;
    logic [11:0] ra;
    logic [31:0] wd;
    logic        wr;

    initial begin
        reset = 1'b1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_pready", 32'(apb.pready), 32'd0);
        check_eq("rst_pslverr", 32'(apb.pslverr), 32'd0);
        check_eq("rst_prdata", apb.prdata, 32'd0);
        check_eq("rst_clear", 32'(ctr_clear), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // 1: status after reset
        apb_xfer(1'b0, 12'h004, '0, rd, er);
        check_eq("t1_status", rd, 32'd0);

        // 2: software snapshot of a ramp
        apb_xfer(1'b1, 12'h000, 32'd1, rd, er);
        apb_xfer(1'b0, 12'h114, '0, rd, er);
        check_eq("t2_ctr5", rd, 32'h50);
        apb_xfer(1'b0, 12'h00C, '0, rd, er);
        check_eq("t2_snapcyc", rd, 32'h1234);
        apb_xfer(1'b0, 12'h004, '0, rd, er);
        check_eq("t2_status", rd, 32'h0001_0001);
        apb_xfer(1'b0, 12'h000, '0, rd, er);
        check_eq("t2_ctrl_rd", rd, 32'd0);

        // 3: periodic snapshots every 4 cycles
        ctr_mode = 1;
        cctr_run = 1'b1;
        apb_xfer(1'b1, 12'h008, 32'd4, rd, er);
        apb_xfer(1'b0, 12'h008, '0, rd, er);
        apb_xfer(1'b0, 12'h004, '0, s1, er);
        repeat (16) @(negedge clk);
        apb_xfer(1'b0, 12'h004, '0, s2, er);
        check_eq("t3_seq_step", 32'(s2[31:16] - s1[31:16]), 32'd5);
        apb_xfer(1'b0, 12'h00C, '0, s1, er);
        repeat (16) @(negedge clk);
        apb_xfer(1'b0, 12'h00C, '0, s2, er);
        check_eq("t3_cyc_step", s2 - s1, 32'd20);
        apb_xfer(1'b1, 12'h008, 32'd0, rd, er);
        apb_xfer(1'b0, 12'h004, '0, s1, er);
        repeat (16) @(negedge clk);
        apb_xfer(1'b0, 12'h004, '0, s2, er);
        check_eq("t3_seq_frozen", 32'(s2[31:16] - s1[31:16]), 32'd0);

        // 4: saturation and snapshot+clear
        ctr_mode = 2;
        @(negedge clk);
        apb_xfer(1'b1, 12'h000, 32'd3, rd, er);
        check_eq("t4_clr_hi", 32'(ctr_clear), 32'd1);
        @(negedge clk);
        check_eq("t4_clr_lo", 32'(ctr_clear), 32'd0);
        apb_xfer(1'b0, 12'h10C, '0, rd, er);
        check_eq("t4_ctr3", rd, 32'hFFFF_FFFF);
        apb_xfer(1'b0, 12'h004, '0, rd, er);
        check_eq("t4_sat", 32'(rd[1]), 32'd1);
        apb_xfer(1'b1, 12'h000, 32'd2, rd, er);
        apb_xfer(1'b0, 12'h10C, '0, rd, er);

        // 5: error responses
        ctr_mode = 1;
        apb_xfer(1'b0, 12'(12'h100 + 4 * NUM), '0, rd, er);
        check_eq("t5_oob_err", 32'(er), 32'd1);
        check_eq("t5_oob_data", rd, 32'd0);
        apb_xfer(1'b1, 12'h00C, 32'hDEAD_BEEF, rd, er);
        check_eq("t5_wr_ro_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 12'h00C, '0, rd, er);
        apb_xfer(1'b0, 12'h7FC, '0, rd, er);
        check_eq("t5_7fc_err", 32'(er), 32'd1);

        // 6: every-cycle timer merged with a software snapshot
        apb_xfer(1'b1, 12'h008, 32'd1, rd, er);
        apb_xfer(1'b0, 12'h004, '0, s1, er);
        apb_xfer(1'b1, 12'h000, 32'd1, rd, er);
        repeat (12) @(negedge clk);
        apb_xfer(1'b0, 12'h004, '0, s2, er);
        check_eq("t6_no_double", 32'(s2[31:16] - s1[31:16]), 32'd20);

        // 6b: reset while the slave is in its first access cycle
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h004;
        @(negedge clk);
        apb.penable = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_pready", 32'(apb.pready), 32'd0);
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_rst_pready2", 32'(apb.pready), 32'd0);
        apb_xfer(1'b0, 12'h004, '0, rd, er);
        check_eq("t6_rst_status", rd, 32'd0);
        apb_xfer(1'b0, 12'h008, '0, rd, er);
        check_eq("t6_rst_period", rd, 32'd0);
        apb_xfer(1'b0, 12'h00C, '0, rd, er);
        check_eq("t6_rst_snapcyc", rd, 32'd0);
        apb_xfer(1'b0, 12'h100, '0, rd, er);
        check_eq("t6_rst_ctr0", rd, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = 12'h000;
                1:       ra = 12'h004;
                2:       ra = 12'h008;
                3:       ra = 12'h00C;
                4, 5:    ra = 12'(12'h100 + 4 * $urandom_range(0, NUM + 3));
                6:       ra = 12'h7FC;
                default: ra = 12'(12'h010 + $urandom_range(0, 3));
            endcase
            wr = ($urandom_range(0, 9) < 3);
            if (ra[11:2] == 10'd0)      wd = 32'($urandom_range(0, 3));
            else if (ra[11:2] == 10'd2) wd = 32'($urandom_range(0, 9));
            else                        wd = $urandom;
            apb_xfer(wr, ra, wd, rd, er);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
